// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: register/Tnew/Tuse codes and the
// per-stage {a3, tnew} record used by the hazard scoreboard.
package pipeline_defs;

  localparam int REG_W  = 5;
  localparam int TNEW_W = 2;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_RA   = 5'd31;

  localparam logic [TNEW_W-1:0] TUSE_NONE  = 2'd3;
  localparam logic [TNEW_W-1:0] TUSE_BR    = 2'd0;
  localparam logic [TNEW_W-1:0] TUSE_ALU   = 2'd1;
  localparam logic [TNEW_W-1:0] TUSE_SW_RT = 2'd2;

  localparam logic [TNEW_W-1:0] TNEW_JAL = 2'd0;
  localparam logic [TNEW_W-1:0] TNEW_ALU = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_LW  = 2'd2;

  typedef struct packed {
    logic [REG_W-1:0]  a3;
    logic [TNEW_W-1:0] tnew;
  } stage_info_t;

  function automatic logic [TNEW_W-1:0] sat_dec(
    input logic [TNEW_W-1:0] x
  );
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_cmp.sv
// Single-operand hazard check against the E and M producers.
// Ports: valid_i, src_i, tuse_i, e_a3_i/e_tnew_i, m_a3_i/m_tnew_i -> hazard_o.
module hazard_cmp
  import pipeline_defs::*;
#(
  parameter int REG_W  = pipeline_defs::REG_W,
  parameter int TNEW_W = pipeline_defs::TNEW_W
) (
  input  logic              valid_i,
  input  logic [REG_W-1:0]  src_i,
  input  logic [TNEW_W-1:0] tuse_i,
  input  logic [REG_W-1:0]  e_a3_i,
  input  logic [TNEW_W-1:0] e_tnew_i,
  input  logic [REG_W-1:0]  m_a3_i,
  input  logic [TNEW_W-1:0] m_tnew_i,
  output logic              hazard_o
);

  logic e_hit;
  logic m_hit;

  // Both producers are checked; the younger E entry does not mask M.
  assign e_hit = (src_i == e_a3_i) && (e_tnew_i > tuse_i);
  assign m_hit = (src_i == m_a3_i) && (m_tnew_i > tuse_i);

  always_comb begin
    hazard_o = 1'b0;
    if (valid_i && (src_i != '0) && (tuse_i != TNEW_W'(TUSE_NONE))) begin
      hazard_o = e_hit || m_hit;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// E/M/W destination + Tnew tracker driving the D-stage stall decision.
// Ports: D-stage operands in; stall, per-stage a3/tnew and stall_cnt out.
module hazard_scoreboard
  import pipeline_defs::*;
#(
  parameter int REG_W  = pipeline_defs::REG_W,
  parameter int TNEW_W = pipeline_defs::TNEW_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [REG_W-1:0]  d_rs,
  input  logic [REG_W-1:0]  d_rt,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic [REG_W-1:0]  d_a3,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              cnt_clr,
  output logic              stall,
  output logic [REG_W-1:0]  e_a3,
  output logic [TNEW_W-1:0] e_tnew,
  output logic [REG_W-1:0]  m_a3,
  output logic [TNEW_W-1:0] m_tnew,
  output logic [REG_W-1:0]  w_a3,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_info_t      e_q, e_d;
  stage_info_t      m_q, m_d;
  logic [REG_W-1:0] w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic haz_rs;
  logic haz_rt;

  hazard_cmp #(
    .REG_W (REG_W),
    .TNEW_W(TNEW_W)
  ) u_cmp_rs (
    .valid_i (d_valid),
    .src_i   (d_rs),
    .tuse_i  (d_tuse_rs),
    .e_a3_i  (e_q.a3),
    .e_tnew_i(e_q.tnew),
    .m_a3_i  (m_q.a3),
    .m_tnew_i(m_q.tnew),
    .hazard_o(haz_rs)
  );

  hazard_cmp #(
    .REG_W (REG_W),
    .TNEW_W(TNEW_W)
  ) u_cmp_rt (
    .valid_i (d_valid),
    .src_i   (d_rt),
    .tuse_i  (d_tuse_rt),
    .e_a3_i  (e_q.a3),
    .e_tnew_i(e_q.tnew),
    .m_a3_i  (m_q.a3),
    .m_tnew_i(m_q.tnew),
    .hazard_o(haz_rt)
  );

  assign stall = haz_rs || haz_rt;

  always_comb begin
    e_d = '0;
    if (d_valid && !stall) begin
      e_d.a3   = d_a3;
      e_d.tnew = d_tnew;
    end
    m_d.a3   = e_q.a3;
    m_d.tnew = sat_dec(e_q.tnew);
    w_d      = m_q.a3;
  end

  // Clear wins over increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign e_a3      = e_q.a3;
  assign e_tnew    = e_q.tnew;
  assign m_a3      = m_q.a3;
  assign m_tnew    = m_q.tnew;
  assign w_a3      = w_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a ready-time model of the
// in-flight producers predicts stall and stage state each cycle.
module tb_hazard_scoreboard;

  localparam int CW   = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          d_valid = 1'b0;
  logic [4:0]    d_rs = '0, d_rt = '0, d_a3 = '0;
  logic [1:0]    d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
  logic          cnt_clr = 1'b0;
  logic          stall;
  logic [4:0]    e_a3, m_a3, w_a3;
  logic [1:0]    e_tnew, m_tnew;
  logic [CW-1:0] stall_cnt;

  hazard_scoreboard #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_a3(d_a3), .d_tnew(d_tnew), .cnt_clr(cnt_clr),
    .stall(stall), .e_a3(e_a3), .e_tnew(e_tnew),
    .m_a3(m_a3), .m_tnew(m_tnew), .w_a3(w_a3),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int ea3, etn, ma3, mtn, wa3, cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model: each slot (0=E,1=M,2=W) holds the producer's register and the
  // absolute cycle at which its result exists.
  int pa3[3];
  int pready[3];
  int cyc = 0;
  int mcnt = 0;

  function automatic int rem(int k);
    return (pready[k] > cyc) ? pready[k] - cyc : 0;
  endfunction

  function automatic bit mhaz(int s, int tuse);
    if (!d_valid || s == 0 || tuse == 3) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (pa3[k] == s && rem(k) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mstall();
    return mhaz(int'(d_rs), int'(d_tuse_rs)) ||
           mhaz(int'(d_rt), int'(d_tuse_rt));
  endfunction

  function automatic void mreset();
    for (int k = 0; k < 3; k++) begin
      pa3[k] = 0;
      pready[k] = 0;
    end
    mcnt = 0;
  endfunction

  function automatic void madvance(bit st);
    pa3[2] = pa3[1]; pready[2] = pready[1];
    pa3[1] = pa3[0]; pready[1] = pready[0];
    if (d_valid && !st) begin
      pa3[0] = int'(d_a3);
      pready[0] = cyc + 1 + int'(d_tnew);
    end else begin
      pa3[0] = 0;
      pready[0] = 0;
    end
    cyc++;
    if (cnt_clr) mcnt = 0;
    else if (st && mcnt < CMAX) mcnt++;
  endfunction

  task automatic chk(string nm, int act, int exv);
    checks++;
    if (act != exv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall",  int'(stall),     e.st);
      chk("e_a3",   int'(e_a3),      e.ea3);
      chk("e_tnew", int'(e_tnew),    e.etn);
      chk("m_a3",   int'(m_a3),      e.ma3);
      chk("m_tnew", int'(m_tnew),    e.mtn);
      chk("w_a3",   int'(w_a3),      e.wa3);
      chk("cnt",    int'(stall_cnt), e.cnt);
    end
  end

  task automatic drive(int v, int rs, int rt, int trs, int trt,
                       int a3, int tn, int clr);
    d_valid = v[0]; d_rs = rs[4:0]; d_rt = rt[4:0];
    d_tuse_rs = trs[1:0]; d_tuse_rt = trt[1:0];
    d_a3 = a3[4:0]; d_tnew = tn[1:0]; cnt_clr = clr[0];
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.st  = int'(mstall());
    e.ea3 = pa3[0]; e.etn = rem(0);
    e.ma3 = pa3[1]; e.mtn = rem(1);
    e.wa3 = pa3[2]; e.cnt = mcnt;
    return e;
  endfunction

  task automatic step(int v, int rs, int rt, int trs, int trt,
                      int a3, int tn, int clr);
    exp_t e;
    drive(v, rs, rt, trs, trt, a3, tn, clr);
    e = predict();
    q.push_back(e);
    @(posedge clk);
    madvance(e.st[0]);
    #1;
  endtask

  initial begin
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", int'(stall), 0);
    chk("rst_e_a3", int'(e_a3), 0);
    chk("rst_m_a3", int'(m_a3), 0);
    chk("rst_w_a3", int'(w_a3), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    rst_n = 1'b1;

    // lw $8 then addu rs=8: one stall, then proceeds
    step(1, 0, 0, 3, 3, 8, 2, 0);
    step(1, 8, 9, 1, 1, 10, 1, 0);
    step(1, 8, 9, 1, 1, 10, 1, 0);
    step(0, 0, 0, 3, 3, 0, 0, 0);
    // lw $9 then beq rs=9: two stalls
    step(1, 0, 0, 3, 3, 9, 2, 0);
    step(1, 9, 0, 0, 3, 0, 0, 0);
    step(1, 9, 0, 0, 3, 0, 0, 0);
    step(1, 9, 0, 0, 3, 0, 0, 0);
    // lw $10 then sw rt=10; jal then jr $31
    step(1, 0, 0, 3, 3, 10, 2, 0);
    step(1, 0, 10, 3, 2, 0, 0, 0);
    step(1, 0, 0, 3, 3, 31, 0, 0);
    step(1, 31, 0, 0, 3, 0, 0, 0);
    // $0 producer and bubbles never stall
    step(1, 0, 0, 3, 3, 0, 2, 0);
    step(1, 0, 0, 0, 3, 0, 0, 0);
    step(1, 0, 0, 3, 3, 5, 2, 0);
    step(0, 5, 5, 0, 0, 6, 2, 0);
    step(0, 6, 5, 0, 0, 7, 1, 0);
    step(1, 5, 0, 0, 3, 0, 0, 0);
    // saturate the counter, then clear during a stall
    step(1, 0, 0, 3, 3, 0, 0, 1);
    for (int i = 0; i < 1800; i++) step(1, 8, 0, 0, 3, 8, 2, 0);
    chk("cnt_sat", mcnt, CMAX);
    for (int i = 0; i < 3; i++) step(1, 8, 0, 0, 3, 8, 2, 1);
    step(1, 0, 0, 3, 3, 0, 0, 0);

    // async reset mid-stall
    step(1, 0, 0, 3, 3, 8, 2, 0);
    begin
      exp_t e;
      drive(1, 8, 0, 1, 3, 11, 1, 0);
      e = predict();
      q.push_back(e);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_stall", int'(stall), 0);
      chk("ar_e_a3", int'(e_a3), 0);
      chk("ar_m_a3", int'(m_a3), 0);
      chk("ar_w_a3", int'(w_a3), 0);
      chk("ar_cnt", int'(stall_cnt), 0);
      mreset();
      rst_n = 1'b1;
      #1;
      chk("ar_post_stall", int'(stall), int'(mstall()));
      chk("ar_post_zero", int'(stall), 0);
      @(posedge clk);
      madvance(mstall());
      #1;
    end

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) != 0) ? 1 : 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
           ($urandom_range(0, 49) == 0) ? 1 : 0);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
